// File: rtl/nurse_call_pkg.sv
// Shared types and helpers for the nurse-call controller.
// Escalation is compiled in only when NURSE_CALL_ESCALATE_EN is defined.
package nurse_call_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int MAX_BEDS = 16;
    localparam int MAX_ID_W = 4;

    // Index of the lowest set bit among the first 'width' bits; 0 if none set.
    function automatic logic [MAX_ID_W-1:0] lowest_set(input logic [MAX_BEDS-1:0] vec,
                                                       input int width);
        logic [MAX_ID_W-1:0] idx;
        idx = '0;
        for (int i = MAX_BEDS - 1; i >= 0; i--) begin
            if (i < width && vec[i]) begin
                idx = MAX_ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/nurse_call_sync.sv
// One call channel: 2-flop synchroniser followed by a rising-edge pulse.
// The channel only arms after it has seen a real low sample following reset,
// so a button held through reset must be released and pressed again.
module nurse_call_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_rise
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic [1:0] r_fill;
    logic       r_armed;

    // Synchronise the raw switch and track when the pipeline holds real samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_meta  <= i_raw;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_fill  <= {r_fill[0], 1'b1};
            r_armed <= r_armed | (r_fill[1] & ~r_sync);
        end
    end

    assign o_rise = r_sync & ~r_prev & r_armed;

endmodule

// File: rtl/nurse_call_ctrl.sv
// Nurse-call controller: latches per-bed call edges, serves them one at a
// time in fixed priority (bed 0 highest) with LED and blinking buzzer until ack.
// Define NURSE_CALL_ESCALATE_EN to build the unacknowledged-call alarm.
module nurse_call_ctrl
    import nurse_call_pkg::*;
#(
    parameter int N_BEDS     = 4,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int ESC_CYCLES = 500_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_BEDS-1:0]         call,
    input  logic                      ack,
    output logic [N_BEDS-1:0]         led,
    output logic [$clog2(N_BEDS)-1:0] active_id,
    output logic [N_BEDS-1:0]         pending,
    output logic                      busy,
    output logic                      buzz,
    output logic                      alarm
);

    localparam int ID_W    = $clog2(N_BEDS);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [N_BEDS-1:0]  w_rise;
    logic [ID_W-1:0]    w_next_id;
    logic [N_BEDS-1:0]  w_next_onehot;

    state_t             r_state;
    logic [N_BEDS-1:0]  r_pending;
    logic [N_BEDS-1:0]  r_led;
    logic [ID_W-1:0]    r_active_id;
    logic               r_busy;
    logic               r_buzz;
    logic [BLINK_W-1:0] r_blink_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < N_BEDS; gi++) begin : g_chan
            nurse_call_sync u_sync (
                .clk    (clk),
                .rst    (rst),
                .i_raw  (call[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    assign w_next_id     = ID_W'(lowest_set(MAX_BEDS'(r_pending), N_BEDS));
    assign w_next_onehot = N_BEDS'(1) << w_next_id;

    // Pending requests: edges set bits, ack clears the served bit; set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else if (r_state == SERVE && ack) begin
            r_pending <= (r_pending & ~r_led) | w_rise;
        end else begin
            r_pending <= r_pending | w_rise;
        end
    end

`ifdef NURSE_CALL_ESCALATE_EN
    localparam int ESC_W = $clog2(ESC_CYCLES);
    logic [ESC_W-1:0] r_esc_cnt;
    logic             r_alarm;
`else
    logic w_unused_esc;
    assign w_unused_esc = (ESC_CYCLES < 2);
`endif

    // Serving FSM with registered LED, id, busy, buzzer and alarm outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_led       <= '0;
            r_active_id <= '0;
            r_busy      <= 1'b0;
            r_buzz      <= 1'b0;
            r_blink_cnt <= '0;
`ifdef NURSE_CALL_ESCALATE_EN
            r_esc_cnt   <= '0;
            r_alarm     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_pending != '0) begin
                        r_state     <= SERVE;
                        r_active_id <= w_next_id;
                        r_led       <= w_next_onehot;
                        r_busy      <= 1'b1;
                        r_buzz      <= 1'b1;
                        r_blink_cnt <= '0;
`ifdef NURSE_CALL_ESCALATE_EN
                        r_esc_cnt   <= '0;
`endif
                    end
                end
                SERVE: begin
                    if (ack) begin
                        r_state     <= IDLE;
                        r_active_id <= '0;
                        r_led       <= '0;
                        r_busy      <= 1'b0;
                        r_buzz      <= 1'b0;
                        r_blink_cnt <= '0;
`ifdef NURSE_CALL_ESCALATE_EN
                        r_esc_cnt   <= '0;
                        r_alarm     <= 1'b0;
`endif
                    end else begin
                        if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                            r_blink_cnt <= '0;
                            r_buzz      <= ~r_buzz;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                        end
`ifdef NURSE_CALL_ESCALATE_EN
                        if (r_esc_cnt == ESC_W'(ESC_CYCLES - 1)) begin
                            r_alarm <= 1'b1;
                        end else begin
                            r_esc_cnt <= r_esc_cnt + 1'b1;
                        end
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign led       = r_led;
    assign active_id = r_active_id;
    assign pending   = r_pending;
    assign busy      = r_busy;
    assign buzz      = r_buzz;
`ifdef NURSE_CALL_ESCALATE_EN
    assign alarm     = r_alarm;
`else
    assign alarm     = 1'b0;
`endif

endmodule

// File: tb/tb_nurse_call_ctrl.sv
// Directed bench for nurse_call_ctrl (N_BEDS=4, BLINK_DIV=4, ESC_CYCLES=10).
// The escalation section runs only when NURSE_CALL_ESCALATE_EN is defined.
module tb_nurse_call_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] call;
    logic       ack;
    logic [3:0] led;
    logic [1:0] active_id;
    logic [3:0] pending;
    logic       busy;
    logic       buzz;
    logic       alarm;

    int total = 0;
    int bad   = 0;

    nurse_call_ctrl #(
        .N_BEDS     (4),
        .BLINK_DIV  (4),
        .ESC_CYCLES (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .call      (call),
        .ack       (ack),
        .led       (led),
        .active_id (active_id),
        .pending   (pending),
        .busy      (busy),
        .buzz      (buzz),
        .alarm     (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst  = 1'b1;
        call = 4'b1111;
        ack  = 1'b0;

        // Reset with all buttons held
        cyc(3);
        chk("rst_led",     32'(led),       32'h0);
        chk("rst_pending", 32'(pending),   32'h0);
        chk("rst_busy",    32'(busy),      32'h0);
        chk("rst_buzz",    32'(buzz),      32'h0);
        chk("rst_id",      32'(active_id), 32'h0);
        chk("rst_alarm",   32'(alarm),     32'h0);
        rst = 1'b0;
        cyc(6);
        chk("held_pending", 32'(pending), 32'h0);
        chk("held_busy",    32'(busy),    32'h0);
        call = 4'b0000;
        cyc(4);
        chk("release_pending", 32'(pending), 32'h0);

        // Single call on bed 2, buzzer pattern, ack
        call = 4'b0100;
        cyc(1);
        call = 4'b0000;
        chk("single_k_pending", 32'(pending), 32'h0);
        cyc(1);
        chk("single_k1_pending", 32'(pending), 32'h0);
        cyc(1);
        chk("single_k2_pending", 32'(pending), 32'h4);
        chk("single_k2_busy",    32'(busy),    32'h0);
        cyc(1);
        chk("single_led",  32'(led),       32'h4);
        chk("single_id",   32'(active_id), 32'h2);
        chk("single_busy", 32'(busy),      32'h1);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("buzz_%0d", i), 32'(buzz), (i < 4 || i == 8) ? 32'h1 : 32'h0);
            if (i < 8) cyc(1);
        end
        chk("single_led_hold", 32'(led), 32'h4);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("ack_led",     32'(led),       32'h0);
        chk("ack_busy",    32'(busy),      32'h0);
        chk("ack_buzz",    32'(buzz),      32'h0);
        chk("ack_pending", 32'(pending),   32'h0);
        chk("ack_id",      32'(active_id), 32'h0);

        // Ack while idle is ignored
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        cyc(1);
        chk("idle_ack_busy", 32'(busy), 32'h0);

        // Priority without preemption
        call = 4'b1000;
        cyc(1);
        call = 4'b0000;
        cyc(3);
        chk("prio_led3", 32'(led),       32'h8);
        chk("prio_id3",  32'(active_id), 32'h3);
        call = 4'b0001;
        cyc(1);
        call = 4'b0000;
        cyc(2);
        chk("prio_pending", 32'(pending), 32'h9);
        cyc(1);
        chk("prio_no_preempt", 32'(led), 32'h8);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("prio_gap_led",     32'(led),     32'h0);
        chk("prio_gap_busy",    32'(busy),    32'h0);
        chk("prio_gap_pending", 32'(pending), 32'h1);
        cyc(1);
        chk("prio_led0", 32'(led),       32'h1);
        chk("prio_id0",  32'(active_id), 32'h0);
        chk("prio_busy", 32'(busy),      32'h1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        cyc(2);

        // Set-wins collision on bed 1
        call = 4'b0010;
        cyc(1);
        call = 4'b0000;
        cyc(3);
        chk("coll_led1", 32'(led), 32'h2);
        cyc(2);
        call = 4'b0010;
        cyc(1);
        call = 4'b0000;
        cyc(1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("coll_pending", 32'(pending), 32'h2);
        chk("coll_busy",    32'(busy),    32'h0);
        cyc(1);
        chk("coll_reserve_led", 32'(led), 32'h2);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("coll_done_pending", 32'(pending), 32'h0);
        cyc(2);

`ifdef NURSE_CALL_ESCALATE_EN
        // Escalation after ten unacknowledged SERVE cycles
        call = 4'b0100;
        cyc(1);
        call = 4'b0000;
        cyc(3);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("esc_low_%0d", i), 32'(alarm), 32'h0);
            cyc(1);
        end
        chk("esc_high",      32'(alarm), 32'h1);
        cyc(2);
        chk("esc_held",      32'(alarm), 32'h1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("esc_ack_alarm", 32'(alarm), 32'h0);
        chk("esc_ack_busy",  32'(busy),  32'h0);
        cyc(2);
`endif

        // Reset in the middle of SERVE
        call = 4'b1000;
        cyc(1);
        call = 4'b0000;
        cyc(3);
        chk("mid_busy", 32'(busy), 32'h1);
        cyc(12);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_rst_led",     32'(led),       32'h0);
        chk("mid_rst_busy",    32'(busy),      32'h0);
        chk("mid_rst_pending", 32'(pending),   32'h0);
        chk("mid_rst_buzz",    32'(buzz),      32'h0);
        chk("mid_rst_alarm",   32'(alarm),     32'h0);
        chk("mid_rst_id",      32'(active_id), 32'h0);
        cyc(5);
        chk("post_rst_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nurse_call_ctrl.md
# nurse_call_ctrl

Parametrised nurse-call controller for an N-bed ward. It synchronises each bed's call button and latches a request on each rising edge. It serves pending requests one at a time in fixed priority order (bed 0 highest) and holds the served bed's LED and a blinking buzzer until the nurse acknowledges. It sits between the board's call switches/ack button and the LED/buzzer outputs, and replaces the purely combinational priority indicator.

## Interface
- `N_BEDS`, 4: number of call channels, 2..16.
- `BLINK_DIV`, 25_000_000: clk cycles per buzzer half-period, ≥2.
- `ESC_CYCLES`, 500_000_000: unacknowledged clk cycles before escalation, ≥2 (used only with escalation compiled in).

Ports:
- `clk` input 1: single system clock.
- `rst` input 1: synchronous, active-high reset.
- `call` input N_BEDS: raw asynchronous call switches, active-high level.
- `ack` input 1: nurse acknowledge, treated as a one-cycle pulse (already synchronised/debounced upstream).
- `led` output N_BEDS: one-hot, the bed currently being served; all-zero when idle.
- `active_id` output $clog2(N_BEDS): index of the served bed; 0 when idle.
- `pending` output N_BEDS: latched, not-yet-acknowledged requests, including the one being served.
- `busy` output 1: high while a call is being served.
- `buzz` output 1: square wave while busy, low otherwise.
- `alarm` output 1: escalation flag.

## Operation
- Per channel: 2-flop synchroniser, then rising-edge detect. An edge sets `pending[i]`. A held button does not re-request.
- FSM states: IDLE, SERVE.
  - IDLE:
    - `busy=0`, `led=0`, `active_id=0`, `buzz=0`.
    - If `pending != 0`: latch `active_id` = lowest set index and go to SERVE.
  - SERVE:
    - `led` = one-hot of `active_id`, `busy=1`.
    - No preemption: a higher-priority request arriving during SERVE only sets its pending bit.
    - On `ack`: clear `pending[active_id]` and go to IDLE.
- `ack` in IDLE is ignored.
- Simultaneous set and clear of the same pending bit (new edge in the same cycle as `ack`): set wins, so the bed is re-served later.
- Buzzer: counter 0..BLINK_DIV-1, reset on SERVE entry. `buzz` toggles at each wrap and starts high on SERVE entry.
- Reset:
  - All outputs 0, pending cleared, synchroniser and edge registers cleared, FSM forced to IDLE, counters cleared.
  - Applies mid-SERVE with no residual state.
  - A button held through reset registers a new edge only after release and re-press.

## Timing
- Call first sampled high at edge k: sync2 high after k+1; `pending[i]` visible after edge k+2.
- IDLE→SERVE on the edge after pending becomes non-zero (k+3); `led`, `busy`, `active_id` are valid from then.
- `ack` sampled at edge m: `led`/`busy` low and pending bit cleared after m.
- Earliest next SERVE entry is m+1. Every served call therefore shows at least one IDLE cycle between services.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro `NURSE_CALL_ESCALATE_EN`.
  - Defined:
    - Escalation counter clears on SERVE entry and counts each SERVE cycle.
    - When the count reaches ESC_CYCLES-1, `alarm` goes high on the next edge.
    - `alarm` stays high until `ack` (cleared together with `busy`) or `rst`.
  - Undefined: no counter is built, `alarm` is tied 0, and `ESC_CYCLES` is unused.

## Structure
- Package `nurse_call_pkg`: FSM state enum (IDLE, SERVE), and a `lowest_set` priority-encode function parametrised on width.
- Sub-module `nurse_call_sync`: one channel's 2-flop synchroniser plus rising-edge pulse, with `clk`/`rst`. Instantiated N_BEDS times via generate.

## Test plan
- Reset/idle: assert `rst` 3 cycles with `call=4'b1111` held → all outputs 0. After release with call still held → `pending` stays 0.
- Single call: pulse `call[2]` → `pending=4'b0100` at k+2. `led=4'b0100`, `active_id=2`, `busy=1` at k+3. `ack` → `led=0` next edge.
- Priority/no preemption: `call[3]`, then `call[0]` during SERVE of bed 3 → `led` stays `4'b1000`. After `ack`, one IDLE cycle, then `led=4'b0001`.
- Set-wins collision: new `call[1]` edge in the same cycle as `ack` of bed 1 → `pending[1]` stays 1 and bed 1 is re-served.
- Buzzer: BLINK_DIV=4 → `buzz` high 4 cycles, low 4 cycles while busy. Drops to 0 the edge after `ack`.
- Escalation (macro defined, ESC_CYCLES=10): no `ack` → `alarm=1` on the 11th SERVE edge. `ack` clears it. Mid-SERVE `rst` → alarm and all outputs 0 next edge.
